// File: rtl/conv_control_param.sv
// Parametrised convolution sequencer: loads filters and the picture window, drives the MAC handshake, packs results and writes them back.
// Define CONV_CTRL_MEM_STALL_EN to add the mem_ready back-pressure input for memory-facing states.
module conv_control_param #(
    parameter int NUM_FILTERS  = 2,
    parameter int FILTER_WORDS = 4,
    parameter int WIN_WORDS    = 16,
    parameter int ROW_WORDS    = 4,
    parameter int MACS_PER_ROW = 13,
    parameter int NUM_SLIDES   = 12,
    parameter int PACK         = 4,
    parameter int ADDR_W       = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            mac_done,
`ifdef CONV_CTRL_MEM_STALL_EN
    input  logic                            mem_ready,
`endif
    output logic [ADDR_W-1:0]               rd_addr,
    output logic [ADDR_W-1:0]               wr_addr,
    output logic                            re,
    output logic                            we,
    output logic                            addr_sel,
    output logic [NUM_FILTERS-1:0]          filter_write,
    output logic [$clog2(FILTER_WORDS)-1:0] filter_idx,
    output logic                            pic_write,
    output logic                            pic_shift,
    output logic                            pic_read,
    output logic                            read_filter,
    output logic                            mac_start,
    output logic                            shift_reg_write,
    output logic                            ans_shift,
    output logic                            busy,
    output logic                            done
);

    localparam int F_W  = (NUM_FILTERS  > 1) ? $clog2(NUM_FILTERS)  : 1;
    localparam int W_W  = (FILTER_WORDS > 1) ? $clog2(FILTER_WORDS) : 1;
    localparam int MC_W = $clog2(MACS_PER_ROW + 1);
    localparam int SL_W = (NUM_SLIDES   > 0) ? $clog2(NUM_SLIDES + 1) : 1;
    localparam int RW_W = (ROW_WORDS    > 1) ? $clog2(ROW_WORDS)    : 1;
    localparam int PK_W = (PACK         > 1) ? $clog2(PACK)         : 1;

    localparam logic [F_W-1:0]    F_LAST     = F_W'(NUM_FILTERS - 1);
    localparam logic [W_W-1:0]    W_LAST     = W_W'(FILTER_WORDS - 1);
    localparam logic [ADDR_W-1:0] WIN_LAST   = ADDR_W'(WIN_WORDS - 1);
    localparam logic [RW_W-1:0]   ROW_LAST   = RW_W'(ROW_WORDS - 1);
    localparam logic [MC_W-1:0]   MAC_LAST   = MC_W'(MACS_PER_ROW);
    localparam logic [SL_W-1:0]   SLIDE_LAST = SL_W'(NUM_SLIDES);
    localparam logic [PK_W-1:0]   PK_LAST    = PK_W'(PACK - 1);

    if (longint'(NUM_FILTERS) * longint'(FILTER_WORDS) > (longint'(1) << ADDR_W)) begin : g_chk_filter
        $error("conv_control_param: filter region does not fit in ADDR_W");
    end
    if (longint'(WIN_WORDS) + longint'(NUM_SLIDES) * longint'(ROW_WORDS) > (longint'(1) << ADDR_W)) begin : g_chk_picture
        $error("conv_control_param: picture region does not fit in ADDR_W");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_LDF,
        S_LDP,
        S_MAC,
        S_MACD,
        S_WRITE,
        S_SHIFT,
        S_FLUSH,
        S_RELOAD,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [F_W-1:0]    f_cnt;
    logic [W_W-1:0]    w_cnt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] wptr;
    logic [MC_W-1:0]   mac_cnt;
    logic [PK_W-1:0]   pack_cnt;
    logic [SL_W-1:0]   slide_cnt;
    logic [RW_W-1:0]   row_cnt;
    logic              mem_ok;
    logic              row_end;
    logic              last_slide;

`ifdef CONV_CTRL_MEM_STALL_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    assign row_end    = (mac_cnt == MAC_LAST);
    assign last_slide = (slide_cnt == SLIDE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory-facing states only strobe re/we/write enables while the memory accepts the beat.
    always_comb begin
        state_nxt       = state;
        rd_addr         = '0;
        wr_addr         = '0;
        re              = 1'b0;
        we              = 1'b0;
        addr_sel        = 1'b0;
        filter_write    = '0;
        filter_idx      = '0;
        pic_write       = 1'b0;
        pic_shift       = 1'b0;
        pic_read        = 1'b0;
        read_filter     = 1'b0;
        mac_start       = 1'b0;
        shift_reg_write = 1'b0;
        ans_shift       = 1'b0;
        busy            = (state != S_IDLE);
        done            = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LDF;
                end
            end
            S_LDF: begin
                re           = mem_ok;
                addr_sel     = 1'b1;
                rd_addr      = ADDR_W'(f_cnt) * ADDR_W'(FILTER_WORDS) + ADDR_W'(w_cnt);
                filter_write = mem_ok ? (NUM_FILTERS'(1) << f_cnt) : '0;
                filter_idx   = w_cnt;
                if (mem_ok && (w_cnt == W_LAST) && (f_cnt == F_LAST)) begin
                    state_nxt = S_LDP;
                end
            end
            S_LDP: begin
                re        = mem_ok;
                pic_write = mem_ok;
                rd_addr   = ptr;
                if (mem_ok && (ptr == WIN_LAST)) begin
                    state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                mac_start       = 1'b1;
                pic_read        = 1'b1;
                read_filter     = 1'b1;
                shift_reg_write = mac_done;
                if (mac_done) begin
                    state_nxt = S_MACD;
                end
            end
            S_MACD: begin
                state_nxt = (pack_cnt == '0) ? S_WRITE : S_SHIFT;
            end
            S_WRITE: begin
                wr_addr = wptr;
                we      = mem_ok;
                if (mem_ok) begin
                    if (row_end && last_slide) begin
                        state_nxt = S_DONE;
                    end else if (row_end) begin
                        pic_shift = 1'b1;
                        state_nxt = S_RELOAD;
                    end else begin
                        state_nxt = S_MAC;
                    end
                end
            end
            S_SHIFT: begin
                ans_shift = 1'b1;
                if (row_end && last_slide) begin
                    state_nxt = S_FLUSH;
                end else if (row_end) begin
                    pic_shift = 1'b1;
                    state_nxt = S_RELOAD;
                end else begin
                    state_nxt = S_MAC;
                end
            end
            S_FLUSH: begin
                wr_addr = wptr;
                we      = mem_ok;
                if (mem_ok) begin
                    state_nxt = S_DONE;
                end
            end
            S_RELOAD: begin
                re        = mem_ok;
                pic_write = mem_ok;
                rd_addr   = ptr;
                if (mem_ok && (row_cnt == ROW_LAST)) begin
                    state_nxt = S_MAC;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Result packing runs continuously across rows, so pack_cnt is only cleared at the start of a run.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_cnt     <= '0;
            w_cnt     <= '0;
            ptr       <= '0;
            wptr      <= '0;
            mac_cnt   <= '0;
            pack_cnt  <= '0;
            slide_cnt <= '0;
            row_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        f_cnt     <= '0;
                        w_cnt     <= '0;
                        ptr       <= '0;
                        wptr      <= '0;
                        mac_cnt   <= '0;
                        pack_cnt  <= '0;
                        slide_cnt <= '0;
                        row_cnt   <= '0;
                    end
                end
                S_LDF: begin
                    if (mem_ok) begin
                        if (w_cnt == W_LAST) begin
                            w_cnt <= '0;
                            f_cnt <= (f_cnt == F_LAST) ? '0 : f_cnt + F_W'(1);
                        end else begin
                            w_cnt <= w_cnt + W_W'(1);
                        end
                    end
                end
                S_LDP: begin
                    if (mem_ok) begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                S_MAC: begin
                    if (mac_done) begin
                        mac_cnt  <= mac_cnt + MC_W'(1);
                        pack_cnt <= (pack_cnt == PK_LAST) ? '0 : pack_cnt + PK_W'(1);
                    end
                end
                S_WRITE, S_FLUSH: begin
                    if (mem_ok) begin
                        wptr <= wptr + ADDR_W'(1);
                    end
                end
                S_RELOAD: begin
                    if (row_cnt == '0) begin
                        mac_cnt <= '0;
                    end
                    if (mem_ok) begin
                        ptr <= ptr + ADDR_W'(1);
                        if (row_cnt == ROW_LAST) begin
                            row_cnt   <= '0;
                            slide_cnt <= slide_cnt + SL_W'(1);
                        end else begin
                            row_cnt <= row_cnt + RW_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_control_param.sv
// Scoreboard bench for conv_control_param: expected memory beats, pack actions and MAC handshakes are queued
// by the stimulus and consumed by an independent monitor whenever the DUT strobes an output.
module tb_conv_control_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mac_done;
`ifdef CONV_CTRL_MEM_STALL_EN
    logic       mem_ready;
`endif
    logic [7:0] rd_addr;
    logic [7:0] wr_addr;
    logic       re;
    logic       we;
    logic       addr_sel;
    logic [1:0] filter_write;
    logic [1:0] filter_idx;
    logic       pic_write;
    logic       pic_shift;
    logic       pic_read;
    logic       read_filter;
    logic       mac_start;
    logic       shift_reg_write;
    logic       ans_shift;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [13:0] exp_rd[$];
    logic [7:0]  exp_wr[$];
    int          exp_act[$];
    int          exp_len[$];
    int          delay_q[$];

    int exp_res, exp_we, exp_ps, exp_rdn;
    int run_res, run_we, run_ps, run_rd;

    conv_control_param dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mac_done       (mac_done),
`ifdef CONV_CTRL_MEM_STALL_EN
        .mem_ready      (mem_ready),
`endif
        .rd_addr        (rd_addr),
        .wr_addr        (wr_addr),
        .re             (re),
        .we             (we),
        .addr_sel       (addr_sel),
        .filter_write   (filter_write),
        .filter_idx     (filter_idx),
        .pic_write      (pic_write),
        .pic_shift      (pic_shift),
        .pic_read       (pic_read),
        .read_filter    (read_filter),
        .mac_start      (mac_start),
        .shift_reg_write(shift_reg_write),
        .ans_shift      (ans_shift),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] allOutputs();
        return 32'({rd_addr, wr_addr, re, we, addr_sel, filter_write, filter_idx, pic_write, pic_shift,
                    pic_read, read_filter, mac_start, shift_reg_write, ans_shift, busy, done});
    endfunction

    // Queue the expected beats of one run: full runs go to done, partial runs stop two beats into the first reload.
    task automatic applyStimulus(input bit full_run, input int first_delay);
        int reload_reads, results, writes;
        reload_reads = full_run ? 48 : 2;
        results      = full_run ? 169 : 13;
        writes       = full_run ? 43 : 3;
        for (int i = 0; i < 8; i++) begin
            exp_rd.push_back({8'(i), 1'b1, (i < 4) ? 2'b01 : 2'b10, 2'(i % 4), 1'b0});
        end
        for (int i = 0; i < 16; i++) begin
            exp_rd.push_back({8'(i), 1'b0, 2'b00, 2'b00, 1'b1});
        end
        for (int i = 0; i < reload_reads; i++) begin
            exp_rd.push_back({8'(16 + i), 1'b0, 2'b00, 2'b00, 1'b1});
        end
        for (int i = 0; i < writes; i++) begin
            exp_wr.push_back(8'(i));
        end
        for (int k = 1; k <= results; k++) begin
            exp_act.push_back((k % 4 == 0) ? 2 : 1);
        end
        if (full_run) begin
            exp_act.push_back(2);
        end
        if (first_delay > 0) begin
            delay_q.push_back(first_delay);
            exp_len.push_back(first_delay + 1);
        end
        exp_res = 169;
        exp_we  = 43;
        exp_ps  = 12;
        exp_rdn = 72;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checkOutput("done_timeout", 32'(done), 32'd1);
        end
    endtask

    // MAC responder: answers each request after the queued delay (0 when none is queued).
    initial begin
        int mac_wait;
        int cur_delay;
        mac_wait  = 0;
        cur_delay = 0;
        mac_done  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mac_start) begin
                if (mac_wait == 0) begin
                    cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                end
                mac_done = (mac_wait >= cur_delay);
                mac_wait++;
            end else begin
                mac_done = 1'b0;
                mac_wait = 0;
            end
        end
    end

    // Monitor: consumes the expectation queues whenever the DUT strobes an output.
    initial begin
        logic [13:0] e_rd;
        logic [7:0]  e_wr;
        int          e_act;
        int          e_len;
        int          mac_len;
        int          srw_bad;
        mac_len = 0;
        srw_bad = 0;
        run_res = 0;
        run_we  = 0;
        run_ps  = 0;
        run_rd  = 0;
        forever begin
            @(negedge clk);
            if (re) begin
                run_rd++;
                if (exp_rd.size() == 0) begin
                    checkOutput("rd_extra", 32'(rd_addr), 32'hFFFF_FFFF);
                end else begin
                    e_rd = exp_rd.pop_front();
                    checkOutput("rd_beat", 32'({rd_addr, addr_sel, filter_write, filter_idx, pic_write}), 32'(e_rd));
                end
            end
            if (we) begin
                run_we++;
                if (exp_wr.size() == 0) begin
                    checkOutput("wr_extra", 32'(wr_addr), 32'hFFFF_FFFF);
                end else begin
                    e_wr = exp_wr.pop_front();
                    checkOutput("wr_addr", 32'(wr_addr), 32'(e_wr));
                end
            end
            if (we || ans_shift) begin
                if (exp_act.size() == 0) begin
                    checkOutput("act_extra", 32'({we, ans_shift}), 32'd0);
                end else begin
                    e_act = exp_act.pop_front();
                    checkOutput("pack_action", 32'({we, ans_shift}), 32'(e_act));
                end
            end
            if (pic_shift) begin
                run_ps++;
            end
            if (shift_reg_write && !(mac_start && mac_done)) begin
                srw_bad++;
            end
            if (mac_start) begin
                mac_len++;
                if (mac_done) begin
                    e_len = (exp_len.size() > 0) ? exp_len.pop_front() : 1;
                    checkOutput("mac_len", 32'(mac_len), 32'(e_len));
                    checkOutput("srw_capture", 32'(shift_reg_write), 32'd1);
                    checkOutput("srw_spurious", 32'(srw_bad), 32'd0);
                    mac_len = 0;
                    run_res++;
                end
            end
            if (done) begin
                checkOutput("run_results", 32'(run_res), 32'(exp_res));
                checkOutput("run_writes", 32'(run_we), 32'(exp_we));
                checkOutput("run_pic_shift", 32'(run_ps), 32'(exp_ps));
                checkOutput("run_reads", 32'(run_rd), 32'(exp_rdn));
            end
            if (done || rst) begin
                run_res = 0;
                run_we  = 0;
                run_ps  = 0;
                run_rd  = 0;
                mac_len = 0;
                srw_bad = 0;
            end
        end
    end

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b1;
`ifdef CONV_CTRL_MEM_STALL_EN
        mem_ready = 1'b1;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_re_we", 32'({re, we}), 32'd0);
        checkOutput("reset_outputs", allOutputs(), 32'd0);

        // Run 1: held start, 5-cycle stall on the first MAC, full run to done.
        applyStimulus(1'b1, 5);
        @(posedge clk);
        #1 rst = 1'b0;
        waitDone(2000);
        @(negedge clk);
        checkOutput("done_pulse_width", 32'(done), 32'd0);
        checkOutput("idle_after_done", 32'(busy), 32'd0);
        applyStimulus(1'b0, 0);
        @(negedge clk);
        checkOutput("restart_with_held_start", 32'(busy), 32'd1);

        // Run 2: reset lands in the second cycle of the first reload.
        n = 0;
        while (!pic_shift && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("first_pic_shift_seen", 32'(pic_shift), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrun_reset_busy", 32'(busy), 32'd0);
        checkOutput("midrun_reset_outputs", allOutputs(), 32'd0);
        checkOutput("midrun_rd_left", 32'(exp_rd.size()), 32'd0);
        checkOutput("midrun_wr_left", 32'(exp_wr.size()), 32'd0);
        checkOutput("midrun_act_left", 32'(exp_act.size()), 32'd0);

        // Run 3: fresh start must restart both address pointers from zero.
        applyStimulus(1'b1, 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
`ifdef CONV_CTRL_MEM_STALL_EN
        repeat (12) @(posedge clk);
        #1 mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_re", 32'(re), 32'd0);
            checkOutput("stall_pic_write", 32'(pic_write), 32'd0);
            checkOutput("stall_rd_addr", 32'(rd_addr), 32'd4);
        end
        @(posedge clk);
        #1 mem_ready = 1'b1;
`endif
        waitDone(2000);
        @(negedge clk);
        checkOutput("final_done_pulse", 32'(done), 32'd0);
        checkOutput("final_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("final_stays_idle", 32'(busy), 32'd0);
        checkOutput("final_rd_left", 32'(exp_rd.size()), 32'd0);
        checkOutput("final_wr_left", 32'(exp_wr.size()), 32'd0);
        checkOutput("final_act_left", 32'(exp_act.size()), 32'd0);
        checkOutput("final_len_left", 32'(exp_len.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
